// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encoding and slice width for the nibble-serial adder
package adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_adder.sv
// rtl/nibble_adder.sv - 4-bit ripple adder with carry-in, one full-adder cell per bit
module nibble_adder
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - sequences a WIDTH-bit add/sub through one shared nibble adder
module nibble_serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = $clog2(NSLICE);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] nib_a, nib_b, nib_s;
    logic               nib_cout;

    assign nib_a = a_q[cnt_q*SLICE_W +: SLICE_W];
    assign nib_b = b_q[cnt_q*SLICE_W +: SLICE_W];

    nibble_adder u_nibble_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_cout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1: invert B here, the +1 rides in as carry-in.
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[cnt_q*SLICE_W +: SLICE_W] = nib_s;
                carry_d = nib_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NSLICE - 1)) begin
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[SLICE_W-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

endmodule
